// File: rtl/md_scheduler.sv
// md_scheduler
// Multiply/divide sequencer for the 5-stage pipeline. It accepts MD ops from
// the E stage and owns the HI/LO registers. The fixed mult/div latency is
// modelled with a countdown counter. A stall request goes to the hazard
// controller so that MD-class instructions in D wait until HI/LO are final.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-low reset
//   E_md_op     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved (none)
//   E_rs_data   forwarded rs operand in E
//   E_rt_data   forwarded rt operand in E
//   D_is_md     D-stage instruction is an MD-class instruction
//   busy        operation in flight
//   start       combinational: mult/div op in E while not busy
//   E_MD_stall  combinational: D_is_md & (start | busy)
//   HI, LO      architectural HI/LO registers
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_is_md,
  output logic        busy,
  output logic        start,
  output logic        E_MD_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic        commit;
  logic [31:0] op_a, op_b;
  logic        op_signed;

  logic [63:0] ext_a, ext_b, product;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, quo_mag, rem_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_valid;

  assign busy       = (state != IDLE);
  assign start      = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && !busy;
  assign E_MD_stall = D_is_md & (start | busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Ops that arrive while busy do not reach this logic, because only IDLE
  // looks at start. The countdown therefore cannot be restarted.
  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU)) begin
            state_next = RUN_MUL;
            count_next = 8'(MULT_CYCLES);
          end else begin
            state_next = RUN_DIV;
            count_next = 8'(DIV_CYCLES);
          end
        end
      end
      RUN_MUL, RUN_DIV: begin
        count_next = count - 8'd1;
        if (count == 8'd1) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The signed divide is done on magnitudes, and the signs are applied
  // afterwards. As a result, 0x80000000 / -1 gives 0x80000000 with no
  // special case. A zero divisor is replaced by 1 to keep the divider
  // well-defined. Its result is discarded at commit.
  always_comb begin
    neg_a   = op_signed & op_a[31];
    neg_b   = op_signed & op_b[31];
    ext_a   = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    ext_b   = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    product = ext_a * ext_b;
    mag_a   = neg_a ? -op_a : op_a;
    mag_b   = neg_b ? -op_b : op_b;
    div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_mag = mag_a / div_b;
    rem_mag = mag_a % div_b;
    res_hi    = product[63:32];
    res_lo    = product[31:0];
    res_valid = 1'b1;
    if (state == RUN_DIV) begin
      res_lo    = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
      res_hi    = neg_a ? -rem_mag : rem_mag;
      res_valid = (op_b != 32'd0);
    end
  end

  // Operands are captured on the start edge. HI/LO are written either by a
  // commit (only while busy) or by mthi/mtlo (only while idle), so the two
  // write sources never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      if (start) begin
        op_a      <= E_rs_data;
        op_b      <= E_rt_data;
        op_signed <= (E_md_op == OP_MULT) || (E_md_op == OP_DIV);
      end
      if (commit) begin
        if (res_valid) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end else if (!busy && (E_md_op == OP_MTHI)) begin
        HI <= E_rs_data;
      end else if (!busy && (E_md_op == OP_MTLO)) begin
        LO <= E_rs_data;
      end
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler
// Self-checking bench for md_scheduler. A table of mult/div vectors is run
// through the unit, followed by hand-written sequences for reset, the stall
// window, mthi/mtlo, a spurious op while busy, and reset mid-divide.
// Expected HI/LO results are queued when an op starts. They are popped and
// compared when the unit drops busy.
module tb_md_scheduler;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        reset;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_is_md;
  logic        busy;
  logic        start;
  logic        E_MD_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[9];
  res_t sbq[$];
  int   tests;
  int   failed;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_rs_data  (E_rs_data),
    .E_rt_data  (E_rt_data),
    .D_is_md    (D_is_md),
    .busy       (busy),
    .start      (start),
    .E_MD_stall (E_MD_stall),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    E_md_op   = op;
    E_rs_data = rs;
    E_rt_data = rt;
  endtask

  // Pops the oldest expected result and compares it with HI/LO.
  task automatic score(input string name);
    res_t r;
    if (sbq.size() == 0) begin
      check_output({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      r = sbq.pop_front();
      check_output({name, "_HI"}, {32'd0, HI}, {32'd0, r.hi});
      check_output({name, "_LO"}, {32'd0, LO}, {32'd0, r.lo});
    end
  endtask

  // Counts busy cycles, starting from the cycle after start. The bound is
  // large enough that a stuck-busy unit still reaches the summary.
  task automatic count_busy(inout int n);
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vector(input int idx);
    int   n;
    res_t r;
    apply_stimulus(vecs[idx].op, vecs[idx].rs, vecs[idx].rt);
    #1;
    check_output($sformatf("vec%0d_start", idx), {63'd0, start}, 64'd1);
    r.hi = vecs[idx].hi;
    r.lo = vecs[idx].lo;
    sbq.push_back(r);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    n = 0;
    count_busy(n);
    check_output($sformatf("vec%0d_busy_cycles", idx), 64'(n), 64'(vecs[idx].cycles));
    score($sformatf("vec%0d", idx));
  endtask

  initial begin
    int   n;
    res_t r;
    tests  = 0;
    failed = 0;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8] = '{OP_MULT,  32'd2,        32'd3,        32'd0,        32'd6,        5};

    E_md_op   = OP_NONE;
    E_rs_data = 32'd0;
    E_rt_data = 32'd0;
    D_is_md   = 1'b1;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_HI", {32'd0, HI}, 64'd0);
    check_output("reset_LO", {32'd0, LO}, 64'd0);
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_stall", {63'd0, E_MD_stall}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vector(i);

    // Stall window with an MD instruction held in D
    D_is_md = 1'b1;
    apply_stimulus(OP_MULT, 32'd4, 32'd5);
    #1 check_output("stall_md_t0", {63'd0, E_MD_stall}, 64'd1);
    r.hi = 32'd0; r.lo = 32'd20; sbq.push_back(r);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(OP_NONE, 32'd0, 32'd0);
      #1 check_output($sformatf("stall_md_t%0d", k), {63'd0, E_MD_stall}, (k <= 5) ? 64'd1 : 64'd0);
    end
    score("stall_md");

    // The same window with a non-MD instruction in D
    D_is_md = 1'b0;
    apply_stimulus(OP_MULT, 32'd3, 32'd3);
    #1 check_output("stall_nomd_t0", {63'd0, E_MD_stall}, 64'd0);
    r.hi = 32'd0; r.lo = 32'd9; sbq.push_back(r);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(OP_NONE, 32'd0, 32'd0);
      #1 check_output($sformatf("stall_nomd_t%0d", k), {63'd0, E_MD_stall}, 64'd0);
    end
    score("stall_nomd");

    // mtlo: written next cycle, with no busy and no stall
    D_is_md = 1'b1;
    apply_stimulus(OP_MTLO, 32'h1234, 32'd0);
    #1;
    check_output("mtlo_start", {63'd0, start}, 64'd0);
    check_output("mtlo_stall", {63'd0, E_MD_stall}, 64'd0);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    check_output("mtlo_LO", {32'd0, LO}, 64'h1234);
    check_output("mtlo_busy", {63'd0, busy}, 64'd0);

    // mult 2x3 with a spurious multu at t+2, which must be ignored
    apply_stimulus(OP_MULT, 32'd2, 32'd3);
    r.hi = 32'd0; r.lo = 32'd6; sbq.push_back(r);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    apply_stimulus(OP_MULTU, 32'd7, 32'd9);
    #1 check_output("spurious_start", {63'd0, start}, 64'd0);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    n = 2;
    count_busy(n);
    check_output("spurious_busy_cycles", 64'(n), 64'd5);
    score("spurious");

    // mthi: HI is written, LO is kept
    apply_stimulus(OP_MTHI, 32'hABCD, 32'd0);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    check_output("mthi_HI", {32'd0, HI}, 64'hABCD);
    check_output("mthi_LO", {32'd0, LO}, 64'd6);

    // Reset asserted at t+4 of a divide: the in-flight result is lost
    apply_stimulus(OP_DIV, 32'd100, 32'd3);
    apply_stimulus(OP_NONE, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rstdiv_busy", {63'd0, busy}, 64'd0);
    check_output("rstdiv_HI", {32'd0, HI}, 64'd0);
    check_output("rstdiv_LO", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check_output("rstdiv_after_busy", {63'd0, busy}, 64'd0);
    check_output("rstdiv_after_HI", {32'd0, HI}, 64'd0);
    check_output("rstdiv_after_LO", {32'd0, LO}, 64'd0);
    check_output("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
Multiply/divide unit sequencer for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and owns the HI/LO registers.
- Models the fixed multi-cycle latency of mult/div with a countdown counter.
- Drives E_MD_stall into the hazard controller, so any MD-class instruction in D is held until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (legal range 1..255).
- DIV_CYCLES, 10, busy cycles after a div/divu start (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- E_md_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- E_rs_data  input  32  forwarded rs operand in E.
- E_rt_data  input  32  forwarded rt operand in E.
- D_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in flight.
- start  output  1  combinational; E_md_op is 1..4 and busy is 0.
- E_MD_stall  output  1  combinational; D_is_md & (start | busy).
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous assert, low): state IDLE, counter 0, busy 0, HI 0, LO 0, pending result discarded. Deassertion is synchronised externally.
- States:
  - IDLE: busy 0.
  - RUN_MUL: busy 1.
  - RUN_DIV: busy 1.
- IDLE transitions:
  - On start with op 1/2, go to RUN_MUL with counter <= MULT_CYCLES.
  - On start with op 3/4, go to RUN_DIV with counter <= DIV_CYCLES.
  - Operands are latched on the start edge.
- RUN_* behaviour:
  - Counter decrements every cycle.
  - When counter==1, the next edge commits the pending result to HI/LO and returns to IDLE.
- Timing for a start in cycle t:
  - busy is high for cycles t+1..t+N.
  - HI/LO change at the edge ending cycle t+N.
  - An mfhi/mflo entering E at t+N+1 reads the new value.
- Stall: an MD-class instruction in D during cycles t..t+N stalls and enters E no earlier than t+N+1. A non-MD instruction is never stalled by this block.
- Arithmetic:
  - mult: {HI,LO} = signed 32x32 -> 64-bit product.
  - multu: same product, unsigned.
  - div: LO = quotient, HI = remainder, signed, truncating toward zero; remainder takes the sign of the dividend.
  - divu: LO = quotient, HI = remainder, unsigned.
- Divide by zero: full DIV_CYCLES busy period still runs; HI and LO are left unchanged at commit.
- Signed overflow: div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: HI (resp. LO) <= E_rs_data at the edge ending that cycle. No busy and no stall are generated.
- Ops arriving while busy (1..6), which are illegal given the stall: ignored entirely, with no restart, no HI/LO write, and the counter undisturbed.
- start is combinational on the current cycle only. The pipeline bubbles E while D is stalled, so each op is seen exactly once.
- Reset mid-operation: in-flight result is lost; HI/LO read 0 after reset.

Test Plan:
- Reset then idle: reset low for 2 cycles -> HI=0, LO=0, busy=0, E_MD_stall=0 regardless of D_is_md.
- mult: mult of 0xFFFFFFFE by 3 in cycle t -> busy high for exactly cycles t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA after the edge ending t+5. The same operands as multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div: div of -7 by 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu of 7 by 0 -> busy 10 cycles, HI/LO unchanged.
- Stall window: D_is_md=1 held from cycle t with a mult started at t -> E_MD_stall=1 for cycles t..t+5 and 0 at t+6. D_is_md=0 in the same window -> E_MD_stall=0 throughout.
- mtlo, then mult while busy: mtlo of 0x1234 -> LO=0x1234 next cycle, no busy. Then mult 2x3 followed by a spurious multu at t+2 -> ignored; LO=6 after the original 5 cycles.
- Reset mid-divide: reset asserted at cycle t+4 of a div -> busy 0 and HI=LO=0 immediately; no commit after reset release.
